// File: rtl/dadd_pipe.sv
// Elastic add/subtract stage: per-beat wrap or saturating arithmetic with overflow
// flag, followed by a STAGES-deep valid/ready pipeline and a delivered-beat counter.
module dadd_pipe #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int STAGES = 2,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dadd_in_en,
  output logic              dadd_in_rdy,
  input  logic [DWIDTH-1:0] dadd_in,
  input  logic [AWIDTH-1:0] dadd_in_addr,
  input  logic [DWIDTH-1:0] cfg_operand,
  input  logic [1:0]        cfg_mode,
  output logic              dadd_out_en,
  input  logic              dadd_out_rdy,
  output logic [DWIDTH-1:0] dadd_out,
  output logic [AWIDTH-1:0] dadd_out_addr,
  output logic              dadd_out_ovf,
  output logic [CWIDTH-1:0] dadd_out_cnt
);

  // Handshake: a beat transfers on any edge where its valid (en) and ready are both
  // high. Valid never depends on ready; ready is combinational from downstream state.

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] ovf_q, ovf_d;
  logic [STAGES-1:0] load;
  logic [DWIDTH-1:0] data_q [STAGES];
  logic [DWIDTH-1:0] data_d [STAGES];
  logic [AWIDTH-1:0] addr_q [STAGES];
  logic [AWIDTH-1:0] addr_d [STAGES];
  logic [CWIDTH-1:0] cnt_q, cnt_d;

  logic [DWIDTH:0]   sum;
  logic [DWIDTH:0]   diff;
  logic [DWIDTH-1:0] s1_res;
  logic              s1_ovf;

  // A stage may load when it or any stage after it is empty, or the output drains.
  always_comb begin : ready_chain
    logic acc;
    acc  = dadd_out_rdy;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc     = acc | ~vld_q[k];
      load[k] = acc;
    end
  end

  // Operand and mode are applied at acceptance, so the result travels with the beat.
  always_comb begin
    sum    = {1'b0, dadd_in} + {1'b0, cfg_operand};
    diff   = {1'b0, dadd_in} - {1'b0, cfg_operand};
    s1_ovf = 1'b0;
    s1_res = '0;
    if (cfg_mode[1]) begin
      s1_ovf = diff[DWIDTH];
      s1_res = (cfg_mode[0] && s1_ovf) ? '0 : diff[DWIDTH-1:0];
    end else begin
      s1_ovf = sum[DWIDTH];
      s1_res = (cfg_mode[0] && s1_ovf) ? '1 : sum[DWIDTH-1:0];
    end
  end

  always_comb begin
    vld_d = vld_q;
    ovf_d = ovf_q;
    for (int k = 0; k < STAGES; k++) begin
      data_d[k] = data_q[k];
      addr_d[k] = addr_q[k];
    end
    if (load[0]) begin
      vld_d[0] = dadd_in_en;
      if (dadd_in_en) begin
        data_d[0] = s1_res;
        addr_d[0] = dadd_in_addr;
        ovf_d[0]  = s1_ovf;
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (load[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          data_d[k] = data_q[k-1];
          addr_d[k] = addr_q[k-1];
          ovf_d[k]  = ovf_q[k-1];
        end
      end
    end
    cnt_d = cnt_q + CWIDTH'(dadd_out_en & dadd_out_rdy);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ovf_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        addr_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
        addr_q[k] <= addr_d[k];
      end
    end
  end

  assign dadd_in_rdy   = load[0];
  assign dadd_out_en   = vld_q[STAGES-1];
  assign dadd_out      = data_q[STAGES-1];
  assign dadd_out_addr = addr_q[STAGES-1];
  assign dadd_out_ovf  = ovf_q[STAGES-1];
  assign dadd_out_cnt  = cnt_q;

endmodule

// File: tb/tb_dadd_pipe.sv
// Directed bench for dadd_pipe (STAGES=2, CWIDTH=4): table of single-beat vectors,
// then streaming, stall, config-change, reset-abort and counter-wrap sequences.
module tb_dadd_pipe;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int W  = DW + AW + 1;

  logic          clk;
  logic          rst_n;
  logic          dadd_in_en;
  logic          dadd_in_rdy;
  logic [DW-1:0] dadd_in;
  logic [AW-1:0] dadd_in_addr;
  logic [DW-1:0] cfg_operand;
  logic [1:0]    cfg_mode;
  logic          dadd_out_en;
  logic          dadd_out_rdy;
  logic [DW-1:0] dadd_out;
  logic [AW-1:0] dadd_out_addr;
  logic          dadd_out_ovf;
  logic [CW-1:0] dadd_out_cnt;

  int total = 0;
  int bad   = 0;
  int delivered = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] op;
    logic [DW-1:0] din;
    logic [AW-1:0] addr;
    logic [DW-1:0] exp_out;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[7];

  dadd_pipe #(.AWIDTH(AW), .DWIDTH(DW), .STAGES(2), .CWIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .dadd_in_en(dadd_in_en), .dadd_in_rdy(dadd_in_rdy),
    .dadd_in(dadd_in), .dadd_in_addr(dadd_in_addr),
    .cfg_operand(cfg_operand), .cfg_mode(cfg_mode),
    .dadd_out_en(dadd_out_en), .dadd_out_rdy(dadd_out_rdy),
    .dadd_out(dadd_out), .dadd_out_addr(dadd_out_addr),
    .dadd_out_ovf(dadd_out_ovf), .dadd_out_cnt(dadd_out_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dadd_in_en = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // driver: holds the beat until accepted, then returns at posedge+1 with en still high
  task automatic put_beat(input logic [DW-1:0] d, input logic [AW-1:0] a,
                          input logic [DW-1:0] op, input logic [1:0] m,
                          input logic [DW-1:0] eo, input logic eovf);
    bit ok;
    ok = 1'b0;
    dadd_in_en   = 1'b1;
    dadd_in      = d;
    dadd_in_addr = a;
    cfg_operand  = op;
    cfg_mode     = m;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (dadd_in_rdy) begin
        exp_q.push_back({eo, a, eovf});
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("accept");
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("drain");
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every delivered beat must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && dadd_out_en && dadd_out_rdy) begin
      logic [W-1:0] e;
      delivered++;
      if (exp_q.size() == 0) begin
        fail_now("unexpected_beat");
      end else begin
        e = exp_q.pop_front();
        check("out_data", 64'(dadd_out), 64'(e[W-1 -: DW]));
        check("out_addr", 64'(dadd_out_addr), 64'(e[AW:1]));
        check("out_ovf", 64'(dadd_out_ovf), 64'(e[0]));
      end
    end
  end

  initial begin
    int d0;
    vecs[0] = '{2'b00, 32'd1, 32'd5,         32'h10, 32'd6,         1'b0};
    vecs[1] = '{2'b00, 32'd1, 32'hFFFF_FFFF, 32'h11, 32'h0,         1'b1};
    vecs[2] = '{2'b01, 32'd1, 32'hFFFF_FFFF, 32'h12, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{2'b11, 32'd5, 32'd3,         32'h13, 32'h0,         1'b1};
    vecs[4] = '{2'b10, 32'd5, 32'd3,         32'h14, 32'hFFFF_FFFE, 1'b1};
    vecs[5] = '{2'b11, 32'd3, 32'd10,        32'h15, 32'd7,         1'b0};
    vecs[6] = '{2'b01, 32'h10, 32'hFFFF_FFE0, 32'h16, 32'hFFFF_FFF0, 1'b0};

    dadd_in = '0; dadd_in_addr = '0; cfg_operand = '0; cfg_mode = '0;
    dadd_out_rdy = 1'b1;
    do_reset();

    check("rst_out_en", 64'(dadd_out_en), 64'd0);
    check("rst_out", 64'(dadd_out), 64'd0);
    check("rst_addr", 64'(dadd_out_addr), 64'd0);
    check("rst_ovf", 64'(dadd_out_ovf), 64'd0);
    check("rst_cnt", 64'(dadd_out_cnt), 64'd0);
    check("rst_in_rdy", 64'(dadd_in_rdy), 64'd1);

    // single-beat table vectors
    for (int i = 0; i < 7; i++) begin
      put_beat(vecs[i].din, vecs[i].addr, vecs[i].op, vecs[i].mode,
               vecs[i].exp_out, vecs[i].exp_ovf);
      dadd_in_en = 1'b0;
      if (i == 0) begin
        check("lat_not_yet", 64'(dadd_out_en), 64'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 64'(dadd_out_en), 64'd1);
      end
      drain();
      check("vec_cnt", 64'(dadd_out_cnt), 64'(i + 1));
    end

    // 8-beat stream with a 4-cycle output stall mid-stream
    do_reset();
    d0 = delivered;
    fork
      begin
        for (int i = 0; i < 8; i++)
          put_beat(32'(i), 32'h100 + 32'(i), 32'd2, 2'b00, 32'(i + 2), 1'b0);
        dadd_in_en = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 dadd_out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("full_in_rdy", 64'(dadd_in_rdy), 64'd0);
        check("full_out_en", 64'(dadd_out_en), 64'd1);
        repeat (2) @(posedge clk);
        #1 dadd_out_rdy = 1'b1;
      end
    join
    drain();
    check("stream_beats", 64'(delivered - d0), 64'd8);
    check("stream_cnt", 64'(dadd_out_cnt), 64'd8);

    // operand change while earlier beats are stalled in the pipe
    do_reset();
    dadd_out_rdy = 1'b0;
    put_beat(32'd10, 32'h200, 32'd1, 2'b00, 32'd11, 1'b0);
    put_beat(32'd11, 32'h201, 32'd1, 2'b00, 32'd12, 1'b0);
    fork
      begin
        put_beat(32'd20, 32'h202, 32'd100, 2'b00, 32'd120, 1'b0);
        put_beat(32'd21, 32'h203, 32'd100, 2'b00, 32'd121, 1'b0);
        put_beat(32'd22, 32'h204, 32'd100, 2'b00, 32'd122, 1'b0);
        dadd_in_en = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 dadd_out_rdy = 1'b1;
      end
    join
    drain();
    check("cfg_cnt", 64'(dadd_out_cnt), 64'd5);

    // asynchronous reset with two stalled beats
    do_reset();
    dadd_out_rdy = 1'b0;
    put_beat(32'd7, 32'h300, 32'd1, 2'b00, 32'd8, 1'b0);
    put_beat(32'd8, 32'h301, 32'd1, 2'b00, 32'd9, 1'b0);
    dadd_in_en = 1'b0;
    @(negedge clk);
    check("stall_out_en", 64'(dadd_out_en), 64'd1);
    check("stall_out", 64'(dadd_out), 64'd8);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_en", 64'(dadd_out_en), 64'd0);
    check("arst_out", 64'(dadd_out), 64'd0);
    check("arst_addr", 64'(dadd_out_addr), 64'd0);
    check("arst_cnt", 64'(dadd_out_cnt), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    dadd_out_rdy = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("arst_no_stale", 64'(dadd_out_en), 64'd0);
    check("arst_cnt_after", 64'(dadd_out_cnt), 64'd0);

    // counter wrap: 17 deliveries on a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++)
      put_beat(32'(i * 7), 32'h400 + 32'(i), 32'd3, 2'b00, 32'(i * 7 + 3), 1'b0);
    dadd_in_en = 1'b0;
    drain();
    check("wrap_cnt", 64'(dadd_out_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
